// File: rtl/mic_mem_arbiter.sv
// mic_mem_arbiter
//   Two-requester arbiter sharing the single DRAM/MMU port between the CPU
//   data path (port C) and the VirtIO micro controller (port M). One access
//   at a time goes downstream. Each requester gets its own stall and
//   read-data register.
//
//   Request encoding: 2'd0 code, 2'd1 write, 2'd2 read, 2'd3 none.
//
//   Ports:
//     CLK, RST_X                      clock, synchronous active-low reset
//     cpu_req/addr/wdata/ctrl         CPU request fields (2'd3 = idle)
//     cpu_stall, cpu_rdata            CPU hold indication and read data
//     mic_req/addr/wdata/ctrl         micro controller request fields
//     mic_stall, mic_rdata            micro controller hold and read data
//     mem_req/addr/wdata/ctrl         registered downstream request
//     mem_ack, mem_rdata              downstream completion pulse and data
//     owner                           current grant (0 = CPU, 1 = mic)
//     err                             sticky timeout flag
//
//   Build option: define ARB_TIMEOUT_EN to enable the BUSY watchdog.
//   It aborts an access after TIMEOUT (1..255) cycles without mem_ack.
//   Without the macro, BUSY waits indefinitely and err is tied low.
module mic_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST_X,
  input  logic [1:0]        cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [2:0]        cpu_ctrl,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  input  logic [1:0]        mic_req,
  input  logic [ADDR_W-1:0] mic_addr,
  input  logic [31:0]       mic_wdata,
  input  logic [2:0]        mic_ctrl,
  output logic              mic_stall,
  output logic [31:0]       mic_rdata,
  output logic [1:0]        mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_ctrl,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              owner,
  output logic              err
);

  localparam logic [1:0] REQ_WRITE = 2'd1;
  localparam logic [1:0] REQ_NONE  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic              owner_r;
  logic              last_r;       // port granted most recently
  logic [1:0]        mem_req_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [31:0]       mem_wdata_r;
  logic [2:0]        mem_ctrl_r;
  logic [31:0]       cpu_rdata_r;
  logic [31:0]       mic_rdata_r;

  logic              cpu_act_s;
  logic              mic_act_s;
  logic              grant_mic_s;
  logic [1:0]        sel_req_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [31:0]       sel_wdata_s;
  logic [2:0]        sel_ctrl_s;

`ifdef ARB_TIMEOUT_EN
  // Count value seen on the TIMEOUT-th BUSY cycle without an ack.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_cnt_r;
  logic       err_r;
`endif

  // A request code other than "none" asks for an access.
  function automatic logic is_active(input logic [1:0] req);
    return (req != REQ_NONE);
  endfunction

  // Code fetches and reads return data; writes do not.
  function automatic logic returns_data(input logic [1:0] req);
    return (req != REQ_WRITE) && (req != REQ_NONE);
  endfunction

  // Arbitration: a lone requester wins outright. When both request, the
  // port that was not granted last time wins.
  always_comb begin
    cpu_act_s   = is_active(cpu_req);
    mic_act_s   = is_active(mic_req);
    grant_mic_s = 1'b0;
    if (cpu_act_s && mic_act_s) begin
      grant_mic_s = ~last_r;
    end else begin
      grant_mic_s = mic_act_s;
    end
  end

  // Route the winner's request fields toward the mem_* registers.
  always_comb begin
    sel_req_s   = cpu_req;
    sel_addr_s  = cpu_addr;
    sel_wdata_s = cpu_wdata;
    sel_ctrl_s  = cpu_ctrl;
    if (grant_mic_s) begin
      sel_req_s   = mic_req;
      sel_addr_s  = mic_addr;
      sel_wdata_s = mic_wdata;
      sel_ctrl_s  = mic_ctrl;
    end else begin
      sel_req_s   = cpu_req;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
      sel_ctrl_s  = cpu_ctrl;
    end
  end

  // Arbiter FSM plus the downstream request and read-data registers.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state_r     <= ST_IDLE;
      owner_r     <= 1'b0;
      last_r      <= 1'b1;   // makes the CPU win the first contested grant
      mem_req_r   <= REQ_NONE;
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h0000_0000;
      mem_ctrl_r  <= 3'd3;
      cpu_rdata_r <= 32'h0000_0000;
      mic_rdata_r <= 32'h0000_0000;
`ifdef ARB_TIMEOUT_EN
      tmo_cnt_r   <= 8'd0;
      err_r       <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cpu_act_s || mic_act_s) begin
            mem_req_r   <= sel_req_s;
            mem_addr_r  <= sel_addr_s;
            mem_wdata_r <= sel_wdata_s;
            mem_ctrl_r  <= sel_ctrl_s;
            owner_r     <= grant_mic_s;
            last_r      <= grant_mic_s;
            state_r     <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_r   <= 8'd0;
`endif
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          // An ack wins over a watchdog expiry in the same cycle.
          if (mem_ack) begin
            if (returns_data(mem_req_r)) begin
              if (owner_r) begin
                mic_rdata_r <= mem_rdata;
              end else begin
                cpu_rdata_r <= mem_rdata;
              end
            end else begin
              state_r <= ST_DONE;
            end
            mem_req_r <= REQ_NONE;
            state_r   <= ST_DONE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (tmo_cnt_r == TMO_LAST) begin
            if (returns_data(mem_req_r)) begin
              if (owner_r) begin
                mic_rdata_r <= 32'hDEAD_BEEF;
              end else begin
                cpu_rdata_r <= 32'hDEAD_BEEF;
              end
            end else begin
              state_r <= ST_DONE;
            end
            err_r     <= 1'b1;
            mem_req_r <= REQ_NONE;
            state_r   <= ST_DONE;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
`else
          else begin
            state_r <= ST_BUSY;
          end
`endif
        end
        ST_DONE: begin
          // Completion cycle: the owner's stall is released, no new grant.
          state_r <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= REQ_NONE;
        end
      endcase
    end
  end

  // Stall is combinational so the owner is released in the DONE cycle.
  assign cpu_stall = cpu_act_s && !((state_r == ST_DONE) && !owner_r);
  assign mic_stall = mic_act_s && !((state_r == ST_DONE) && owner_r);

  assign cpu_rdata = cpu_rdata_r;
  assign mic_rdata = mic_rdata_r;
  assign mem_req   = mem_req_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_ctrl  = mem_ctrl_r;
  assign owner     = owner_r;

`ifdef ARB_TIMEOUT_EN
  assign err = err_r;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mic_mem_arbiter.sv
// Testbench for mic_mem_arbiter: a table of per-cycle vectors followed by
// hand-written multi-cycle sequences.
module tb_mic_mem_arbiter;

  logic        CLK;
  logic        RST_X;
  logic [1:0]  cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_ctrl;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic [1:0]  mic_req;
  logic [31:0] mic_addr;
  logic [31:0] mic_wdata;
  logic [2:0]  mic_ctrl;
  logic        mic_stall;
  logic [31:0] mic_rdata;
  logic [1:0]  mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_ctrl;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        owner;
  logic        err;

  int checks;
  int failures;

  mic_mem_arbiter #(.ADDR_W(32), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST_X(RST_X),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ctrl(cpu_ctrl), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .mic_req(mic_req), .mic_addr(mic_addr), .mic_wdata(mic_wdata),
    .mic_ctrl(mic_ctrl), .mic_stall(mic_stall), .mic_rdata(mic_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ctrl(mem_ctrl), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .owner(owner), .err(err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [1:0]  creq;
    logic [31:0] caddr;
    logic [1:0]  mreq;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [2:0]  mctrl;
    logic        ack;
    logic [31:0] rd;
    logic        cst;
    logic        mst;
    logic [1:0]  ereq;
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic [2:0]  ectrl;
    logic        own;
    logic [31:0] crd;
    logic [31:0] mrd;
  } vec_t;

  localparam int NV = 26;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req   = 2'd3; cpu_addr = 32'h0; cpu_wdata = 32'h0; cpu_ctrl = 3'd2;
    mic_req   = 2'd3; mic_addr = 32'h0; mic_wdata = 32'h0; mic_ctrl = 3'd0;
    mem_ack   = 1'b0; mem_rdata = 32'h0;
  endtask

  initial begin
    int stall_cnt;
    bit done;
    checks   = 0;
    failures = 0;

    //           rst   creq  caddr          mreq  maddr          mwd            mctrl ack   rd              cst   mst   ereq  eaddr          ewd            ectrl own   crd            mrd
    vecs[0]  = '{1'b1, 2'd2, 32'h8000_0010, 2'd3, 32'h0,         32'h0,         3'd0, 1'b0, 32'h0,          1'b1, 1'b0, 2'd3, 32'h0,         32'h0,         3'd3, 1'b0, 32'h0,         32'h0};
    vecs[1]  = '{1'b1, 2'd2, 32'h8000_0010, 2'd3, 32'h0,         32'h0,         3'd0, 1'b0, 32'h0,          1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0,         3'd2, 1'b0, 32'h0,         32'h0};
    vecs[2]  = '{1'b1, 2'd2, 32'h8000_0010, 2'd3, 32'h0,         32'h0,         3'd0, 1'b0, 32'h0,          1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0,         3'd2, 1'b0, 32'h0,         32'h0};
    vecs[3]  = '{1'b1, 2'd2, 32'h8000_0010, 2'd3, 32'h0,         32'h0,         3'd0, 1'b1, 32'h1234_5678,  1'b1, 1'b0, 2'd2, 32'h8000_0010, 32'h0,         3'd2, 1'b0, 32'h0,         32'h0};
    vecs[4]  = '{1'b1, 2'd2, 32'h8000_0010, 2'd3, 32'h0,         32'h0,         3'd0, 1'b0, 32'h0,          1'b0, 1'b0, 2'd3, 32'h8000_0010, 32'h0,         3'd2, 1'b0, 32'h1234_5678, 32'h0};
    vecs[5]  = '{1'b1, 2'd3, 32'h0,         2'd3, 32'h0,         32'h0,         3'd0, 1'b0, 32'h0,          1'b0, 1'b0, 2'd3, 32'h8000_0010, 32'h0,         3'd2, 1'b0, 32'h1234_5678, 32'h0};
    vecs[6]  = '{1'b0, 2'd3, 32'h0,         2'd3, 32'h0,         32'h0,         3'd0, 1'b0, 32'h0,          1'b0, 1'b0, 2'd3, 32'h8000_0010, 32'h0,         3'd2, 1'b0, 32'h1234_5678, 32'h0};
    vecs[7]  = '{1'b1, 2'd2, 32'h0000_1000, 2'd2, 32'h0000_2000, 32'h0,         3'd2, 1'b0, 32'h0,          1'b1, 1'b1, 2'd3, 32'h0,         32'h0,         3'd3, 1'b0, 32'h0,         32'h0};
    vecs[8]  = '{1'b1, 2'd2, 32'h0000_1000, 2'd2, 32'h0000_2000, 32'h0,         3'd2, 1'b1, 32'h1111_1111,  1'b1, 1'b1, 2'd2, 32'h0000_1000, 32'h0,         3'd2, 1'b0, 32'h0,         32'h0};
    vecs[9]  = '{1'b1, 2'd2, 32'h0000_1000, 2'd2, 32'h0000_2000, 32'h0,         3'd2, 1'b0, 32'h0,          1'b0, 1'b1, 2'd3, 32'h0000_1000, 32'h0,         3'd2, 1'b0, 32'h1111_1111, 32'h0};
    vecs[10] = '{1'b1, 2'd2, 32'h0000_3000, 2'd2, 32'h0000_2000, 32'h0,         3'd2, 1'b0, 32'h0,          1'b1, 1'b1, 2'd3, 32'h0000_1000, 32'h0,         3'd2, 1'b0, 32'h1111_1111, 32'h0};
    vecs[11] = '{1'b1, 2'd2, 32'h0000_3000, 2'd2, 32'h0000_2000, 32'h0,         3'd2, 1'b1, 32'h2222_2222,  1'b1, 1'b1, 2'd2, 32'h0000_2000, 32'h0,         3'd2, 1'b1, 32'h1111_1111, 32'h0};
    vecs[12] = '{1'b1, 2'd2, 32'h0000_3000, 2'd2, 32'h0000_2000, 32'h0,         3'd2, 1'b0, 32'h0,          1'b1, 1'b0, 2'd3, 32'h0000_2000, 32'h0,         3'd2, 1'b1, 32'h1111_1111, 32'h2222_2222};
    vecs[13] = '{1'b1, 2'd2, 32'h0000_3000, 2'd2, 32'h0000_4000, 32'h0,         3'd2, 1'b0, 32'h0,          1'b1, 1'b1, 2'd3, 32'h0000_2000, 32'h0,         3'd2, 1'b1, 32'h1111_1111, 32'h2222_2222};
    vecs[14] = '{1'b1, 2'd2, 32'h0000_3000, 2'd2, 32'h0000_4000, 32'h0,         3'd2, 1'b1, 32'h3333_3333,  1'b1, 1'b1, 2'd2, 32'h0000_3000, 32'h0,         3'd2, 1'b0, 32'h1111_1111, 32'h2222_2222};
    vecs[15] = '{1'b1, 2'd3, 32'h0,         2'd3, 32'h0,         32'h0,         3'd0, 1'b0, 32'h0,          1'b0, 1'b0, 2'd3, 32'h0000_3000, 32'h0,         3'd2, 1'b0, 32'h3333_3333, 32'h2222_2222};
    vecs[16] = '{1'b1, 2'd3, 32'h0,         2'd1, 32'h9000_0000, 32'hCAFE_F00D, 3'd2, 1'b0, 32'h0,          1'b0, 1'b1, 2'd3, 32'h0000_3000, 32'h0,         3'd2, 1'b0, 32'h3333_3333, 32'h2222_2222};
    vecs[17] = '{1'b1, 2'd3, 32'h0,         2'd1, 32'h9000_0000, 32'hCAFE_F00D, 3'd2, 1'b0, 32'h0,          1'b0, 1'b1, 2'd1, 32'h9000_0000, 32'hCAFE_F00D, 3'd2, 1'b1, 32'h3333_3333, 32'h2222_2222};
    vecs[18] = '{1'b1, 2'd3, 32'h0,         2'd1, 32'h9000_0004, 32'hFFFF_FFFF, 3'd0, 1'b1, 32'h5555_5555,  1'b0, 1'b1, 2'd1, 32'h9000_0000, 32'hCAFE_F00D, 3'd2, 1'b1, 32'h3333_3333, 32'h2222_2222};
    vecs[19] = '{1'b1, 2'd3, 32'h0,         2'd1, 32'h9000_0000, 32'hCAFE_F00D, 3'd2, 1'b1, 32'h6666_6666,  1'b0, 1'b0, 2'd3, 32'h9000_0000, 32'hCAFE_F00D, 3'd2, 1'b1, 32'h3333_3333, 32'h2222_2222};
    vecs[20] = '{1'b1, 2'd3, 32'h0,         2'd3, 32'h0,         32'h0,         3'd0, 1'b1, 32'h7777_7777,  1'b0, 1'b0, 2'd3, 32'h9000_0000, 32'hCAFE_F00D, 3'd2, 1'b1, 32'h3333_3333, 32'h2222_2222};
    vecs[21] = '{1'b1, 2'd3, 32'h0,         2'd3, 32'h0,         32'h0,         3'd0, 1'b0, 32'h0,          1'b0, 1'b0, 2'd3, 32'h9000_0000, 32'hCAFE_F00D, 3'd2, 1'b1, 32'h3333_3333, 32'h2222_2222};
    vecs[22] = '{1'b1, 2'd2, 32'h8000_0020, 2'd3, 32'h0,         32'h0,         3'd0, 1'b0, 32'h0,          1'b1, 1'b0, 2'd3, 32'h9000_0000, 32'hCAFE_F00D, 3'd2, 1'b1, 32'h3333_3333, 32'h2222_2222};
    vecs[23] = '{1'b0, 2'd2, 32'h8000_0020, 2'd3, 32'h0,         32'h0,         3'd0, 1'b0, 32'h0,          1'b1, 1'b0, 2'd2, 32'h8000_0020, 32'h0,         3'd2, 1'b0, 32'h3333_3333, 32'h2222_2222};
    vecs[24] = '{1'b1, 2'd3, 32'h0,         2'd3, 32'h0,         32'h0,         3'd0, 1'b1, 32'h9999_9999,  1'b0, 1'b0, 2'd3, 32'h0,         32'h0,         3'd3, 1'b0, 32'h0,         32'h0};
    vecs[25] = '{1'b1, 2'd3, 32'h0,         2'd3, 32'h0,         32'h0,         3'd0, 1'b0, 32'h0,          1'b0, 1'b0, 2'd3, 32'h0,         32'h0,         3'd3, 1'b0, 32'h0,         32'h0};

    RST_X = 1'b0;
    idle_inputs();
    repeat (2) @(posedge CLK);

    // Table: drive on the falling edge, compare 1 time unit later.
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      RST_X     = vecs[i].rst;
      cpu_req   = vecs[i].creq;
      cpu_addr  = vecs[i].caddr;
      mic_req   = vecs[i].mreq;
      mic_addr  = vecs[i].maddr;
      mic_wdata = vecs[i].mwd;
      mic_ctrl  = vecs[i].mctrl;
      mem_ack   = vecs[i].ack;
      mem_rdata = vecs[i].rd;
      #1;
      check($sformatf("v%0d.cpu_stall", i), {31'd0, cpu_stall}, {31'd0, vecs[i].cst});
      check($sformatf("v%0d.mic_stall", i), {31'd0, mic_stall}, {31'd0, vecs[i].mst});
      check($sformatf("v%0d.mem_req", i), {30'd0, mem_req}, {30'd0, vecs[i].ereq});
      check($sformatf("v%0d.mem_addr", i), mem_addr, vecs[i].eaddr);
      check($sformatf("v%0d.mem_wdata", i), mem_wdata, vecs[i].ewd);
      check($sformatf("v%0d.mem_ctrl", i), {29'd0, mem_ctrl}, {29'd0, vecs[i].ectrl});
      check($sformatf("v%0d.owner", i), {31'd0, owner}, {31'd0, vecs[i].own});
      check($sformatf("v%0d.cpu_rdata", i), cpu_rdata, vecs[i].crd);
      check($sformatf("v%0d.mic_rdata", i), mic_rdata, vecs[i].mrd);
      check($sformatf("v%0d.err", i), {31'd0, err}, 32'd0);
    end

    // Code fetch with ack on the fifth BUSY cycle: stall high for 6 cycles.
    @(negedge CLK);
    idle_inputs();
    cpu_req   = 2'd0;
    cpu_addr  = 32'h0000_0100;
    stall_cnt = 0;
    done      = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      mem_ack   = (k == 5);
      mem_rdata = (k == 5) ? 32'hC0DE_0001 : 32'h0;
      #1;
      if (cpu_stall) stall_cnt++;
      else done = 1'b1;
      @(negedge CLK);
    end
    check("code.released", {31'd0, done}, 32'd1);
    check("code.stall_cycles", stall_cnt, 32'd6);
    check("code.cpu_rdata", cpu_rdata, 32'hC0DE_0001);
    check("code.mem_req", {30'd0, mem_req}, 32'd3);
    idle_inputs();

`ifdef ARB_TIMEOUT_EN
    // Watchdog: CPU read never acked, TIMEOUT=8 -> 1 IDLE + 8 BUSY stall cycles.
    @(negedge CLK);
    RST_X = 1'b0;
    @(negedge CLK);
    RST_X     = 1'b1;
    cpu_req   = 2'd2;
    cpu_addr  = 32'h8000_0040;
    stall_cnt = 0;
    done      = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      #1;
      if (cpu_stall) stall_cnt++;
      else done = 1'b1;
      @(negedge CLK);
    end
    check("tmo.released", {31'd0, done}, 32'd1);
    check("tmo.stall_cycles", stall_cnt, 32'd9);
    check("tmo.cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
    check("tmo.err", {31'd0, err}, 32'd1);
    idle_inputs();
    repeat (3) @(negedge CLK);
    #1;
    check("tmo.err_sticky", {31'd0, err}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
